code_ram_arbiter: RTL
=====================

Name: code_ram_arbiter

Overview:
- Shares the single port of the 512x16 code RAM between two requesters: port A (JTAG loader, read/write) and port B (core decode-stage instruction fetch, read-only).
- Sits between the requesters and one `ram_bus` port of the dual-port code RAM, freeing the second RAM port.
- Fixed priority to the loader, with a starvation guard so fetch always progresses.
- Returns read data one cycle after grant, tagged by a per-port valid pulse.

Parameters:
ADDR_W, 9, code RAM address width
DATA_W, 16, code RAM word width
STARVE_MAX, 4, consecutive cycles port B may be denied before it is forced to win one arbitration (legal range 1..15)

Ports:
clock  in  1  single clock; all state on posedge
reset  in  1  asynchronous, active-high reset
a_req  in  1  loader request, held until granted
a_we  in  1  loader request is a write when 1
a_addr  in  ADDR_W  loader address
a_wdata  in  DATA_W  loader write data
a_gnt  out  1  loader request accepted this cycle (combinational)
a_rvalid  out  1  a_rdata valid this cycle (registered pulse)
a_rdata  out  DATA_W  loader read data
b_req  in  1  fetch request, held until granted
b_addr  in  ADDR_W  fetch address
b_gnt  out  1  fetch request accepted this cycle (combinational)
b_rvalid  out  1  b_rdata valid this cycle (registered pulse)
b_rdata  out  DATA_W  fetch read data
ram_addr  out  ADDR_W  to code RAM address
ram_wdata  out  DATA_W  to code RAM write data
ram_we  out  1  to code RAM write enable
ram_rdata  in  DATA_W  from code RAM, unregistered output, valid the cycle after address is clocked

Behaviour:
- Interface: one clock named clock; reset named reset, asynchronous, active-high.
- Reset values:
  - a_gnt, b_gnt, ram_we, a_rvalid and b_rvalid are all 0.
  - The pending-read owner register is cleared.
  - starve_cnt = 0 and hold_addr = 0, so ram_addr = 0 and ram_wdata = 0.
  - Grants are forced to 0 while reset is high.
- Arbitration is combinational each cycle:
  - Only A requests: grant A.
  - Only B requests: grant B.
  - Both request: grant A, unless starve_cnt == STARVE_MAX, in which case grant B.
  - At most one grant per cycle.
  - A request with no grant must be held stable by the requester, with address and data unchanged, until granted.
- Issue, in the grant cycle:
  - ram_addr = granted address and ram_we = a_we & a_gnt.
  - ram_wdata = a_wdata when A is granted, otherwise 0.
  - On the clock edge, hold_addr <= granted address.
- Idle cycle (no grant): ram_addr = hold_addr, ram_we = 0, ram_wdata = 0.
- Read return, latency 1:
  - A granted read (B, or A with a_we = 0) sets that port's rvalid for exactly the next cycle.
  - a_rdata and b_rdata are both driven from ram_rdata; each is meaningful only while its rvalid is set.
  - A granted write produces no rvalid.
- Back-to-back operation:
  - A grant is legal every cycle; throughput is 1 access per cycle.
  - rvalid for grant N coincides with the issue of grant N+1.
- starve_cnt, 4 bits, updated at posedge:
  - b_req & ~b_gnt: increment, saturating at STARVE_MAX.
  - b_gnt or ~b_req: clear to 0.
- Read-during-write: A writes address X in cycle N and B reads X in cycle N+1. B must receive the new data; this follows from RAM ordering and needs no bypass.
- Reset mid-operation:
  - A read in flight is dropped and no rvalid is emitted after reset.
  - A write whose grant cycle overlaps reset assertion is not issued, because ram_we is forced 0.
- Address and data widths pass through unchanged, with no truncation or extension.

Test Plan:
- Reset, then A writes 0x1234 at address 5, then A reads address 5 -> a_gnt=1 in both issue cycles, ram_we=1 only on the write, a_rvalid=1 one cycle after the read grant with a_rdata=0x1234, b_rvalid stays 0.
- B alone reads addresses 0,1,2 on consecutive cycles -> b_gnt=1 every cycle, b_rvalid high on 3 consecutive cycles with data for 0,1,2 in order.
- A and B both request continuously, STARVE_MAX=4 -> grant pattern is A,A,A,A,B repeating, starve_cnt saturates at 4 then clears on the B grant.
- A writes 0xBEEF at address 9 in cycle N, B reads address 9 in cycle N+1 -> b_rdata=0xBEEF with b_rvalid in cycle N+2.
- B read granted, reset asserted asynchronously before the next edge -> b_rvalid never asserts, ram_addr=0, all grants 0 until reset deasserts.
- No requests for 3 cycles after an access to address 7 -> ram_addr holds 7, ram_we=0, both rvalid=0.

Source files
------------

// File: rtl/code_ram_arbiter_if.sv
// code_ram_arbiter_if: requester and code RAM signals around the arbiter
interface code_ram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, ram_rdata,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, ram_addr, ram_wdata, ram_we
    );
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_addr, ram_rdata,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/code_ram_arbiter.sv
// code_ram_arbiter: shares one code RAM port between the loader (A, r/w) and
// instruction fetch (B, read-only); loader priority with a starvation guard.
module code_ram_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input logic              clock,
    input logic              reset,
    code_ram_arbiter_if.slave bus
);
    localparam logic [3:0] starve_lim = 4'(STARVE_MAX);
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] hold_addr;
    logic              a_pend;
    logic              b_pend;
    always_comb begin
        bus.b_gnt     = ~reset & bus.b_req & (~bus.a_req | (starve_cnt == starve_lim));
        bus.a_gnt     = ~reset & bus.a_req & ~bus.b_gnt;
        bus.ram_addr  = bus.a_gnt ? bus.a_addr : bus.b_gnt ? bus.b_addr : hold_addr;
        bus.ram_we    = bus.a_gnt & bus.a_we;
        bus.ram_wdata = bus.a_gnt ? bus.a_wdata : '0;
        bus.a_rvalid  = a_pend;
        bus.b_rvalid  = b_pend;
        bus.a_rdata   = bus.ram_rdata;
        bus.b_rdata   = bus.ram_rdata;
    end
    // Idle cycles keep presenting the last address so the RAM output stays put.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            hold_addr  <= '0;
            a_pend     <= 1'b0;
            b_pend     <= 1'b0;
        end else begin
            a_pend     <= bus.a_gnt & ~bus.a_we;
            b_pend     <= bus.b_gnt;
            hold_addr  <= bus.ram_addr;
            starve_cnt <= (bus.b_req & ~bus.b_gnt) ? ((starve_cnt == starve_lim) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
        end
    end
endmodule
